// File: rtl/rx_packet_decoder.sv
// Baseband receive packet decoder: sliding matched-filter preamble search
// followed by integrate-and-dump data-bit decoding into a byte stream.
module rx_packet_decoder #(
    parameter int unsigned                 PREAMB_LEN              = 130,
    parameter logic [PREAMB_LEN-1:0]       IMPULSE_PREAMB_RESPONSE = {
        26'b11001100111100001111111111,
        26'b00110011000011110000000000,
        26'b00110011000011110000000000,
        26'b00110011000011110000000000,
        26'b11001100111100001111111111
    },
    parameter int unsigned                 DATA_LEN                = 42,
    parameter logic [DATA_LEN-1:0]         IMPULSE_DATA_RESPONSE   = {
        14'b00000011110011,
        14'b00000011110011,
        14'b11111100001100
    },
    parameter int unsigned                 NUMBER_OF_DATA          = 160,
    parameter int signed                   PREAMB_THRESHOLD        = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enClk,
    input  logic [1:0] data_in,
    output logic       DataValid,
    output logic [7:0] DataRx
);

    localparam int unsigned CORR_W = $clog2(2 * PREAMB_LEN + 1) + 1;
    localparam int unsigned ACC_W  = $clog2(2 * DATA_LEN + 1) + 2;
    localparam int unsigned K_W    = $clog2(DATA_LEN);
    localparam int unsigned BIT_W  = $clog2(NUMBER_OF_DATA);

    localparam logic signed [CORR_W-1:0] THRESH   = CORR_W'(PREAMB_THRESHOLD);
    localparam logic [K_W-1:0]           K_LAST   = K_W'(DATA_LEN - 1);
    localparam logic [BIT_W-1:0]         BIT_LAST = BIT_W'(NUMBER_OF_DATA - 1);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t                       state;
    logic [PREAMB_LEN-1:0][1:0]   dline;
    logic [K_W-1:0]               samp_cnt;
    logic [BIT_W-1:0]             bit_cnt;
    logic signed [ACC_W-1:0]      acc;
    logic [7:0]                   byte_sr;
    logic                         byte_pend;

    logic signed [CORR_W-1:0]     corr_c;
    logic signed [ACC_W-1:0]      x_c;
    logic signed [ACC_W-1:0]      term_c;
    logic signed [ACC_W-1:0]      acc_sum_c;
    logic                         bit_c;

    // Preamble correlation over the stored window; dline[0] is the newest
    // sample and meets the template LSB, the oldest tap meets the MSB.
    always_comb begin
        corr_c = '0;
        for (int i = 0; i < int'(PREAMB_LEN); i++) begin
            if (IMPULSE_PREAMB_RESPONSE[i]) begin
                corr_c = corr_c - {{(CORR_W-2){dline[i][1]}}, dline[i]};
            end else begin
                corr_c = corr_c + {{(CORR_W-2){dline[i][1]}}, dline[i]};
            end
        end
    end

    // Data integrate step; coefficient 0 comes from the template MSB.
    always_comb begin
        x_c       = {{(ACC_W-2){data_in[1]}}, data_in};
        term_c    = IMPULSE_DATA_RESPONSE[K_LAST - samp_cnt] ? -x_c : x_c;
        acc_sum_c = acc + term_c;
        bit_c     = !acc_sum_c[ACC_W-1] && (acc_sum_c != '0);
    end

    // The detecting edge already consumes the first data sample, so sample
    // 0 of bit 0 is integrated here and the counter continues at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_HUNT;
            dline     <= '0;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            acc       <= '0;
            byte_sr   <= '0;
            byte_pend <= 1'b0;
            DataValid <= 1'b0;
            DataRx    <= '0;
        end else begin
            DataValid <= byte_pend;
            byte_pend <= 1'b0;
            if (byte_pend) begin
                DataRx <= byte_sr;
            end

            if (enClk) begin
                dline <= {dline[PREAMB_LEN-2:0], data_in};
                case (state)
                    ST_HUNT: begin
                        if (corr_c >= THRESH) begin
                            state    <= ST_DATA;
                            acc      <= acc_sum_c;
                            samp_cnt <= K_W'(1);
                            bit_cnt  <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (samp_cnt == K_LAST) begin
                            acc      <= '0;
                            samp_cnt <= '0;
                            byte_sr  <= {byte_sr[6:0], bit_c};
                            if (bit_cnt[2:0] == 3'b111) begin
                                byte_pend <= 1'b1;
                            end
                            if (bit_cnt == BIT_LAST) begin
                                state   <= ST_HUNT;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end else begin
                            acc      <= acc_sum_c;
                            samp_cnt <= samp_cnt + K_W'(1);
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_packet_decoder.sv
// Directed bench for rx_packet_decoder: builds packets from the preamble/data
// templates and checks decoded bytes, strobe timing and reset behaviour.
module tb_rx_packet_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       enClk;
    logic [1:0] data_in;
    logic       DataValid;
    logic [7:0] DataRx;

    localparam logic [25:0]  B13 = 26'b11001100111100001111111111;
    localparam logic [13:0]  B7  = 14'b11111100001100;
    localparam logic [129:0] PRE = {B13, ~B13, ~B13, ~B13, B13};
    localparam logic [41:0]  DAT = {~B7, ~B7, B7};

    logic [7:0] exp_bytes [21] = '{8'hBE, 8'hBD, 8'hBC, 8'hBB, 8'hBA, 8'hB9, 8'hB8,
                                   8'hB7, 8'hB6, 8'hB5, 8'hB4, 8'hB3, 8'hB2, 8'hB1,
                                   8'hF2, 8'hF5, 8'hEF, 8'hED, 8'hEC, 8'hEB, 8'hEA};

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc      = 0;
    int         cap_cyc  = 0;
    bit         rst_arm  = 1'b0;
    logic [7:0] got_q   [$];
    int         got_cyc [$];

    rx_packet_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .enClk     (enClk),
        .data_in   (data_in),
        .DataValid (DataValid),
        .DataRx    (DataRx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (DataValid === 1'b1) begin
            got_q.push_back(DataRx);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: release/apply the reset pulse, drive inputs at negedge.
    task automatic drive(input logic [1:0] s, input logic e);
        @(negedge clk);
        rst = 1'b1;
        if (rst_arm && got_q.size() >= 5) begin
            rst     = 1'b0;
            rst_arm = 1'b0;
            #1;
            check("rst_pulse_valid", 32'(DataValid), 32'd0);
            check("rst_pulse_data", 32'(DataRx), 32'd0);
        end
        data_in = s;
        enClk   = e;
        @(posedge clk);
        cyc++;
    endtask

    task automatic send_sample(input logic v, input bit alt, input int idx);
        drive({v, 1'b1}, 1'b1);
        if (idx == 466) cap_cyc = cyc;
        if (alt) drive(2'b10, 1'b0);
    endtask

    task automatic send_packet(input bit neg, input bit alt, input bit noisy);
        logic [129:0] pre;
        logic [41:0]  dat;
        logic [7:0]   cur;
        logic         v;
        int           idx;
        int unsigned  r;
        pre = PRE;
        dat = DAT;
        idx = 0;
        for (int i = 0; i < 130; i++) begin
            idx++;
            send_sample(pre[129-i] ^ neg, alt, idx);
        end
        for (int by = 0; by < 21; by++) begin
            cur = exp_bytes[by];
            for (int bt = 7; bt >= 0; bt--) begin
                r = $urandom_range(41, 0);
                for (int k = 0; k < 42; k++) begin
                    v = cur[bt] ? dat[41-k] : ~dat[41-k];
                    if (noisy && (((k + int'(r)) % 42) < 10)) v = ~v;
                    idx++;
                    send_sample(v ^ neg, alt, idx);
                end
            end
        end
        repeat (200) drive(2'b00, 1'b1);
    endtask

    task automatic check_packet(input string name, input int n_exp, input int spacing);
        check($sformatf("%s_count", name), 32'(got_q.size()), 32'(n_exp));
        for (int i = 0; i < got_q.size() && i < n_exp; i++) begin
            check($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_bytes[i]));
            if (i == 0) begin
                check($sformatf("%s_latency", name), 32'(got_cyc[0]), 32'(cap_cyc + 1));
            end else begin
                check($sformatf("%s_gap%0d", name, i), 32'(got_cyc[i] - got_cyc[i-1]), 32'(spacing));
            end
        end
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        rst     = 1'b0;
        enClk   = 1'b0;
        data_in = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(DataValid), 32'd0);
        check("reset_data", 32'(DataRx), 32'd0);

        repeat (500) drive(2'b01, 1'b1);
        check("const_count", 32'(got_q.size()), 32'd0);
        check("const_data", 32'(DataRx), 32'd0);
        got_q.delete();
        got_cyc.delete();
        repeat (200) drive(2'b00, 1'b1);

        send_packet(1'b0, 1'b0, 1'b0);
        check_packet("pkt", 20, 336);
        check("hold_last", 32'(DataRx), 32'hEB);

        send_packet(1'b0, 1'b1, 1'b0);
        check_packet("alt", 20, 672);

        rst_arm = 1'b1;
        send_packet(1'b0, 1'b0, 1'b0);
        check("rst_fired", 32'(rst_arm), 32'd0);
        check_packet("rstpkt", 5, 336);
        send_packet(1'b0, 1'b0, 1'b0);
        check_packet("post_rst", 20, 336);

        send_packet(1'b1, 1'b0, 1'b0);
        check_packet("neg", 0, 0);

        send_packet(1'b0, 1'b0, 1'b1);
        check_packet("noisy", 20, 336);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
